// File: rtl/acia_pkg.sv
// Shared constants for the ACIA bus initiator: status bit positions, control
// bytes, register-select encodings and the host FSM state type.
package acia_pkg;

    localparam int ST_RXF = 0;
    localparam int ST_TXE = 1;
    localparam int ST_ERR = 4;
    localparam int ST_IRQ = 7;

    localparam logic [7:0] CTRL_MRST = 8'h03;
    localparam logic [7:0] CTRL_RXIE = 8'h80;

    localparam logic RS_CTRL = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [3:0] {
        MRST,
        CFG,
        SETTLE,
        POLL,
        SCAP,
        RDAT,
        RCAP,
        WDAT,
        WWAIT,
        IDLE
    } host_state_t;

endpackage

// File: rtl/acia_host_timer.sv
// Loadable down-counter that times the SETTLE, RDAT and WWAIT holds.
// Once loaded it decrements to zero and stays there.
module acia_host_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/acia_host.sv
// Bus initiator that configures an ACIA, polls its status and bridges its data
// register to valid/ready TX and RX streams. Optional: ACIA_HOST_IRQ_EN.
module acia_host
    import acia_pkg::*;
#(
    parameter int         PCLK_DIV  = 4,
    parameter logic [7:0] CTRL_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       acia_cs_n,
    output logic       acia_we_n,
    output logic       acia_rs,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout,
    input  logic       acia_irq_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       init_done
);

    localparam int CW = $clog2(2 * PCLK_DIV + 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(PCLK_DIV - 1);
    localparam logic [CW-1:0] WWAIT_LD = CW'(2 * PCLK_DIV - 1);

`ifdef ACIA_HOST_IRQ_EN
    localparam host_state_t POLL_ENTRY = IDLE;
    localparam logic [7:0]  CFG_BYTE   = CTRL_WORD | CTRL_RXIE;
`else
    localparam host_state_t POLL_ENTRY = POLL;
    localparam logic [7:0]  CFG_BYTE   = CTRL_WORD;
    logic irq_unused;
    assign irq_unused = acia_irq_n;
`endif

    host_state_t     state, state_next;
    logic            hold_zero, hold_load;
    logic [CW-1:0]   hold_val;
    logic            err_cap;
    logic            cs_d, we_d, rs_d, txr_d;
    logic [7:0]      din_d;

    acia_host_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load),
        .load_val (hold_val),
        .zero     (hold_zero)
    );

    // Bus outputs are registered from the next state so the strobe lines up
    // with the state register; MRST therefore spends one idle cycle after reset.
    always_comb begin
        state_next = state;
        case (state)
            MRST:    if (!acia_cs_n) state_next = CFG;
            CFG:     state_next = SETTLE;
            SETTLE:  if (hold_zero) state_next = POLL_ENTRY;
`ifdef ACIA_HOST_IRQ_EN
            IDLE:    if (!acia_irq_n || tx_valid) state_next = POLL;
`endif
            POLL:    state_next = SCAP;
            SCAP: begin
                if (acia_dout[ST_RXF] && !rx_valid)     state_next = RDAT;
                else if (acia_dout[ST_TXE] && tx_valid) state_next = WDAT;
                else                                    state_next = POLL_ENTRY;
            end
            RDAT:    if (hold_zero) state_next = RCAP;
            RCAP:    state_next = POLL_ENTRY;
            WDAT:    state_next = WWAIT;
            WWAIT:   if (hold_zero) state_next = POLL_ENTRY;
            default: state_next = MRST;
        endcase
    end

    always_comb begin
        hold_load = 1'b0;
        hold_val  = HOLD_LD;
        if (state_next != state) begin
            case (state_next)
                SETTLE, RDAT: hold_load = 1'b1;
                WWAIT: begin
                    hold_load = 1'b1;
                    hold_val  = WWAIT_LD;
                end
                default: hold_load = 1'b0;
            endcase
        end
    end

    always_comb begin
        cs_d  = 1'b1;
        we_d  = 1'b1;
        rs_d  = RS_CTRL;
        din_d = 8'h00;
        txr_d = 1'b0;
        case (state_next)
            MRST: begin
                cs_d  = 1'b0;
                we_d  = 1'b0;
                din_d = CTRL_MRST;
            end
            CFG: begin
                cs_d  = 1'b0;
                we_d  = 1'b0;
                din_d = CFG_BYTE;
            end
            POLL: cs_d = 1'b0;
            RDAT: begin
                cs_d = 1'b0;
                rs_d = RS_DATA;
            end
            WDAT: begin
                cs_d  = 1'b0;
                we_d  = 1'b0;
                rs_d  = RS_DATA;
                din_d = tx_data;
                txr_d = 1'b1;
            end
            default: cs_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= MRST;
            acia_cs_n <= 1'b1;
            acia_we_n <= 1'b1;
            acia_rs   <= RS_CTRL;
            acia_din  <= 8'h00;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            rx_err    <= 1'b0;
            init_done <= 1'b0;
            err_cap   <= 1'b0;
        end else begin
            state     <= state_next;
            acia_cs_n <= cs_d;
            acia_we_n <= we_d;
            acia_rs   <= rs_d;
            acia_din  <= din_d;
            tx_ready  <= txr_d;
            if (state_next == CFG) init_done <= 1'b1;
            if (state == SCAP) err_cap <= acia_dout[ST_ERR];
            if (state == RCAP) begin
                rx_data  <= acia_dout;
                rx_err   <= err_cap;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acia_host.sv
// Directed bench for acia_host with a small behavioural ACIA register model
// answering the host's bus cycles.
module tb_acia_host;
    import acia_pkg::*;

    localparam int         PDIV    = 4;
    localparam logic [7:0] CW      = 8'h15;
    localparam int         TX_BUSY = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       acia_cs_n, acia_we_n, acia_rs;
    logic [7:0] acia_din;
    logic [7:0] acia_dout = 8'h00;
    logic       acia_irq_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_err;
    logic       init_done;

    int errors = 0;
    int checks = 0;

    acia_host #(.PCLK_DIV(PDIV), .CTRL_WORD(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .acia_cs_n  (acia_cs_n),
        .acia_we_n  (acia_we_n),
        .acia_rs    (acia_rs),
        .acia_din   (acia_din),
        .acia_dout  (acia_dout),
        .acia_irq_n (acia_irq_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_err     (rx_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // ACIA register model
    logic       rx_inj = 1'b0;
    logic [7:0] rx_inj_byte = 8'h00;
    logic       rx_inj_ferr = 1'b0;
    logic       m_rxf = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_rxbyte = 8'h00;
    int         m_txbusy = 0;
    logic [7:0] m_status;
    logic [7:0] txlog[$];
    int         cyc = 0;

    assign m_status = {3'b000, m_err, 2'b00, (m_txbusy == 0), m_rxf};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_txbusy > 0) m_txbusy <= m_txbusy - 1;
        if (!acia_cs_n && acia_we_n) begin
            acia_dout <= acia_rs ? m_rxbyte : m_status;
            if (acia_rs) begin
                m_rxf <= 1'b0;
                m_err <= 1'b0;
            end
        end
        if (!acia_cs_n && !acia_we_n) begin
            if (acia_rs) begin
                m_txbusy <= TX_BUSY;
                txlog.push_back(acia_din);
            end else if (acia_din[1:0] == 2'b11) begin
                m_rxf    <= 1'b0;
                m_err    <= 1'b0;
                m_txbusy <= 0;
            end
        end
        if (rx_inj) begin
            m_err    <= m_err | m_rxf | rx_inj_ferr;
            m_rxf    <= 1'b1;
            m_rxbyte <= rx_inj_byte;
        end
    end

    // Bus monitor
    logic [8:0] wlog[$];
    int cfg_wr = 0;
    int pre_init_data = 0;
    int run = 0;
    int last_run = 0;
    int data_reads = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            cfg_wr = 0;
        end else begin
            if (!acia_cs_n && !acia_we_n) begin
                wlog.push_back({acia_rs, acia_din});
                if (!acia_rs) cfg_wr++;
            end
            if (!acia_cs_n && acia_rs && cfg_wr < 2) pre_init_data++;
        end
        if (!acia_cs_n && acia_we_n && acia_rs) begin
            run++;
        end else if (run > 0) begin
            last_run = run;
            data_reads++;
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_tx_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rx_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wlog.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_data_read(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!acia_cs_n && acia_we_n && acia_rs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic inject(input logic [7:0] b, input logic ferr);
        rx_inj_byte = b;
        rx_inj_ferr = ferr;
        rx_inj      = 1'b1;
        @(negedge clk);
        rx_inj      = 1'b0;
        rx_inj_ferr = 1'b0;
    endtask

    task automatic pulse_rx_ready();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_reinit(input string tag, input int base);
        bit ok;
        wait_writes(base + 2, 100, ok);
        check({tag, "_to"}, 32'(ok), 1);
        if (ok) begin
            check({tag, "_w0"}, 32'(wlog[base]), 32'h003);
            check({tag, "_w1"}, 32'(wlog[base + 1]), {23'd0, 1'b0, CW});
        end
        check({tag, "_done"}, 32'(init_done), 1);
    endtask

    initial begin
        bit ok;
        int c1, c2, snap, base;

        // reset state
        cycles(3);
        check("rst_cs_n", 32'(acia_cs_n), 1);
        check("rst_we_n", 32'(acia_we_n), 1);
        check("rst_rs", 32'(acia_rs), 0);
        check("rst_din", 32'(acia_din), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_err", 32'(rx_err), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_state", 32'(dut.state), 32'(MRST));

        // initialization sequence
        reset_n = 1'b1;
        check_reinit("init", 0);
        cycles(20);
        check("init_no_data_before_cfg", 32'(pre_init_data), 0);

        // TX: first byte goes out, second waits for txe
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        wait_tx_ready(100, ok);
        check("tx1_to", 32'(ok), 1);
        c1 = cyc;
        check("tx1_cs_n", 32'(acia_cs_n), 0);
        check("tx1_we_n", 32'(acia_we_n), 0);
        check("tx1_rs", 32'(acia_rs), 1);
        check("tx1_din", 32'(acia_din), 32'hA5);
        @(negedge clk);
        tx_data = 8'h5A;
        check("tx1_log", 32'(txlog.size()), 1);
        if (txlog.size() > 0) check("tx1_byte", 32'(txlog[0]), 32'hA5);
        wait_tx_ready(300, ok);
        check("tx2_to", 32'(ok), 1);
        c2 = cyc;
        check("tx2_after_txe", 32'((c2 - c1) >= TX_BUSY), 1);
        check("tx2_din", 32'(acia_din), 32'h5A);
        @(negedge clk);
        tx_valid = 1'b0;
        cycles(60);

        // RX with consumer ready
        snap = data_reads;
        inject(8'h3C, 1'b0);
        wait_rx_valid(100, ok);
        check("rx1_to", 32'(ok), 1);
        check("rx1_data", 32'(rx_data), 32'h3C);
        check("rx1_err", 32'(rx_err), 0);
        cycles(3);
        check("rx1_pulse", 32'(rx_valid), 0);
        check("rx1_hold_len", 32'(last_run), PDIV);
        check("rx1_one_read", 32'(data_reads - snap), 1);
        check("rx1_rxf_clear", 32'(m_rxf), 0);

        // RX backpressure, then overrun
        rx_ready = 1'b0;
        inject(8'h11, 1'b0);
        wait_rx_valid(100, ok);
        check("bp_to", 32'(ok), 1);
        inject(8'h22, 1'b0);
        snap = data_reads;
        cycles(50);
        check("bp_held", 32'(rx_valid), 1);
        check("bp_data", 32'(rx_data), 32'h11);
        check("bp_no_read", 32'(data_reads - snap), 0);
        pulse_rx_ready();
        check("bp_consumed", 32'(rx_valid), 0);
        wait_rx_valid(100, ok);
        check("bp2_to", 32'(ok), 1);
        check("bp2_data", 32'(rx_data), 32'h22);
        check("bp2_err", 32'(rx_err), 0);
        inject(8'h44, 1'b0);
        inject(8'h55, 1'b0);
        cycles(20);
        pulse_rx_ready();
        wait_rx_valid(100, ok);
        check("ovr_to", 32'(ok), 1);
        check("ovr_data", 32'(rx_data), 32'h55);
        check("ovr_err", 32'(rx_err), 1);
        rx_ready = 1'b1;
        cycles(5);

        // framing error
        inject(8'h66, 1'b1);
        wait_rx_valid(100, ok);
        check("ferr_to", 32'(ok), 1);
        check("ferr_data", 32'(rx_data), 32'h66);
        check("ferr_err", 32'(rx_err), 1);
        cycles(5);

        // reset during RDAT
        inject(8'h77, 1'b0);
        wait_data_read(100, ok);
        check("rrd_to", 32'(ok), 1);
        base = wlog.size();
        reset_n = 1'b0;
        @(negedge clk);
        check("rrd_cs_n", 32'(acia_cs_n), 1);
        check("rrd_rx_valid", 32'(rx_valid), 0);
        check("rrd_tx_ready", 32'(tx_ready), 0);
        check("rrd_state", 32'(dut.state), 32'(MRST));
        reset_n = 1'b1;
        check_reinit("rrd", base);
        cycles(20);

        // reset during WWAIT with a held rx byte
        rx_ready = 1'b0;
        inject(8'h88, 1'b0);
        wait_rx_valid(100, ok);
        check("rww_rx_to", 32'(ok), 1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        wait_tx_ready(100, ok);
        check("rww_tx_to", 32'(ok), 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("rww_in_wwait", 32'(dut.state), 32'(WWAIT));
        base = wlog.size();
        reset_n = 1'b0;
        @(negedge clk);
        check("rww_cs_n", 32'(acia_cs_n), 1);
        check("rww_rx_valid", 32'(rx_valid), 0);
        check("rww_tx_ready", 32'(tx_ready), 0);
        check("rww_state", 32'(dut.state), 32'(MRST));
        reset_n = 1'b1;
        rx_ready = 1'b1;
        check_reinit("rww", base);
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acia_host.md
Name: acia_host

Overview:
- Hardware bus initiator for the ACIA peripheral: drives its register interface (cs_n/we_n/rs/din) and reads its registered dout, so a byte stream can use the serial port without the 6502.
- Resets and configures the ACIA, then polls the status register.
- Moves bytes from a valid/ready TX stream into the ACIA data register, and from the ACIA data register out to a valid/ready RX stream.
- Sits beside the ACIA on the same clock; the CPU bus is muxed away when the host is in use.

Parameters:
- PCLK_DIV, 4, clk cycles per ACIA pclk pulse. Sets read-hold and write-settle lengths. Must be ≥1.
- CTRL_WORD, 8'h00, control byte written after master reset. Bits 1:0 must not be 2'b11.

Ports:
- clk  in  1  system clock, shared with the ACIA
- reset_n  in  1  synchronous, active-low reset
- acia_cs_n  out  1  ACIA chip select, low-true
- acia_we_n  out  1  ACIA write enable, low-true
- acia_rs  out  1  register select: 0 = control/status, 1 = data
- acia_din  out  8  write data to the ACIA
- acia_dout  in  8  ACIA read data, registered, valid the cycle after a read strobe
- acia_irq_n  in  1  ACIA interrupt, low-true
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid; must be held until accepted
- tx_ready  out  1  accept strobe: byte taken when tx_valid & tx_ready
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid; held until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- rx_err  out  1  framing/overrun flag, captured with rx_data
- init_done  out  1  high once configuration writes are complete

Behaviour:
- Reset (clk edge with reset_n=0) forces these outputs:
  - acia_cs_n=1, acia_we_n=1, acia_rs=0, acia_din=0
  - tx_ready=0, rx_valid=0, rx_data=0, rx_err=0, init_done=0
  - state=MRST, hold counter=0
- Reset mid-operation aborts any access; a held rx byte is discarded.
- Bus cycles:
  - Write: one clk with cs_n=0, we_n=0; the ACIA latches din on that edge.
  - Read: cycle N drives cs_n=0, we_n=1; acia_dout is sampled at cycle N+1.
  - cs_n=1 in every other cycle.
- States:
  - MRST: write 8'h03 to rs=0 (master reset) → CFG.
  - CFG: write CTRL_WORD to rs=0 → SETTLE. init_done=1 from this point on.
  - SETTLE: idle PCLK_DIV cycles → POLL.
  - POLL: read rs=0 → SCAP.
  - SCAP: capture status (bit0 rxf, bit1 txe, bit4 err).
    - If rxf=1 and rx_valid=0 → RDAT.
    - Else if txe=1 and tx_valid=1 → WDAT.
    - Else → POLL.
    - RX has priority when both are possible.
  - RDAT: read rs=1 with cs_n held low for PCLK_DIV cycles, which guarantees overlap with a pclk pulse so the ACIA clears rxf → RCAP.
  - RCAP: rx_data←acia_dout, rx_err←captured status bit4, rx_valid←1 → POLL.
  - WDAT: write tx_data to rs=1. tx_ready=1 in this single cycle → WWAIT.
  - WWAIT: idle 2*PCLK_DIV cycles so txe has cleared before the next poll → POLL.
- rx_valid clears on the cycle after rx_valid & rx_ready.
- While rx_valid=1 the host keeps polling but never reads data. Backpressure is thereby held in the ACIA via rxf, and no byte is lost by the host.
- Simultaneous RCAP and rx_ready: not possible, because RCAP is entered only with rx_valid=0.
- acia_irq_n is ignored unless the optional feature is enabled.
- Hold counter width is clog2(2*PCLK_DIV+1) and it counts down to 0.

Optional Feature:
- Macro ACIA_HOST_IRQ_EN.
- Defined:
  - CFG writes CTRL_WORD|8'h80 (RX interrupt enable).
  - The transition into POLL waits in state IDLE until acia_irq_n=0 or tx_valid=1.
  - This gives no bus activity while the link is quiet.
- Undefined: continuous polling as above; acia_irq_n is unused.

Decomposition:
- Package acia_pkg:
  - status bit indices (RXF=0, TXE=1, ERR=4, IRQ=7)
  - control constants (CTRL_MRST=8'h03, CTRL_RXIE=8'h80)
  - rs encodings (RS_CTRL=0, RS_DATA=1)
  - state enum
- Optional sub-module acia_host_timer: loadable down-counter used for SETTLE, RDAT and WWAIT. The FSM and bus drivers stay in acia_host.

Test Plan:
- Reset release, CTRL_WORD=8'h15:
  - first write cycle is rs=0, din=8'h03;
  - next write is rs=0, din=8'h15;
  - init_done=1 after the second write;
  - no data-register access before it.
- tx_valid=1, tx_data=8'hA5, ACIA idle: a write with rs=1, din=8'hA5 occurs with tx_ready=1 in that cycle. The ACIA tx line shows an 8N1 frame of 0xA5. The next byte waits until txe=1.
- Drive 8'h3C into the ACIA rx line, rx_ready=1: rx_valid pulses with rx_data=8'h3C, rx_err=0. The data read holds cs_n low for exactly PCLK_DIV cycles, and rxf reads 0 at the next poll.
- rx_ready=0, two bytes 8'h11 then 8'h22 sent:
  - rx_valid holds 8'h11 and no rs=1 read occurs while it is held;
  - after rx_ready, 8'h11 is consumed, then 8'h22 is delivered;
  - ACIA overrun is reflected as rx_err=1 on 8'h22 only if the second byte arrived before the ACIA cleared rxf.
- Bad stop bit on received byte: rx_err=1 alongside rx_data.
- reset_n=0 asserted during RDAT and during WWAIT: next edge has cs_n=1, rx_valid=0, tx_ready=0, state MRST. Re-initialization repeats the 8'h03 then CTRL_WORD writes.
